// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: occupancy counter plus a timed entry/exit gate with one-deep pending requests.
// Optional macro PARKING_REJECT_ALARM_EN enables a one-cycle reject pulse for refused entries.
module parking_gate_ctrl #(
    parameter int CAPACITY         = 16,
    parameter int GATE_OPEN_CYCLES = 40_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    output logic [7:0] count,
    output logic [7:0] free_slots,
    output logic       full,
    output logic       empty,
    output logic       gate_open,
    output logic       gate_dir,
    output logic       reject,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } state_t;

    localparam int            TW     = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [7:0]    CAP    = 8'(CAPACITY);
    localparam logic [TW-1:0] T_LAST = TW'(GATE_OPEN_CYCLES - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pend_in, pend_in_n;
    logic          pend_out, pend_out_n;
    logic [7:0]    count_n;
    logic          gate_open_n, gate_dir_n, reject_n;
    logic          entry_v, exit_v;

    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        pend_in_n   = pend_in;
        pend_out_n  = pend_out;
        count_n     = count;
        gate_open_n = gate_open;
        gate_dir_n  = gate_dir;
        reject_n    = 1'b0;
        entry_v     = entry_req | pend_in;
        exit_v      = exit_req | pend_out;

        case (state)
            IDLE: begin
                // Exit wins a tie; the entry is kept pending for the next idle cycle.
                if (exit_v && count != 8'd0) begin
                    state_n     = OPEN_OUT;
                    count_n     = count - 8'd1;
                    gate_open_n = 1'b1;
                    gate_dir_n  = 1'b0;
                    timer_n     = '0;
                    pend_out_n  = 1'b0;
                    pend_in_n   = entry_v;
                end else begin
                    pend_out_n = 1'b0;
                    if (entry_v) begin
                        pend_in_n = 1'b0;
                        if (count < CAP) begin
                            state_n     = OPEN_IN;
                            count_n     = count + 8'd1;
                            gate_open_n = 1'b1;
                            gate_dir_n  = 1'b1;
                            timer_n     = '0;
                        end else begin
`ifdef PARKING_REJECT_ALARM_EN
                            reject_n = 1'b1;
`else
                            reject_n = 1'b0;
`endif
                        end
                    end
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (entry_req) pend_in_n = 1'b1;
                if (exit_req)  pend_out_n = 1'b1;
                if (timer == T_LAST) begin
                    state_n     = IDLE;
                    gate_open_n = 1'b0;
                    timer_n     = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            pend_in    <= 1'b0;
            pend_out   <= 1'b0;
            count      <= 8'd0;
            free_slots <= CAP;
            full       <= 1'b0;
            empty      <= 1'b1;
            gate_open  <= 1'b0;
            gate_dir   <= 1'b0;
            reject     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            pend_in    <= pend_in_n;
            pend_out   <= pend_out_n;
            count      <= count_n;
            free_slots <= CAP - count_n;
            full       <= (count_n == CAP);
            empty      <= (count_n == 8'd0);
            gate_open  <= gate_open_n;
            gate_dir   <= gate_dir_n;
            reject     <= reject_n;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed table-driven bench for parking_gate_ctrl with CAPACITY=2, GATE_OPEN_CYCLES=4.
// Reject expectations follow PARKING_REJECT_ALARM_EN when the bench is built with it.
module tb_parking_gate_ctrl;

    localparam int CAP = 2;
    localparam int GOC = 4;
`ifdef PARKING_REJECT_ALARM_EN
    localparam logic RJ = 1'b1;
`else
    localparam logic RJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [7:0] count, free_slots;
    logic       full, empty, gate_open, gate_dir, reject;
    logic [1:0] state_dbg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       ex;
        logic [7:0] cnt;
        logic       go;
        logic       dir;
        logic       rej;
    } vec_t;

    vec_t vecs[$];

    parking_gate_ctrl #(.CAPACITY(CAP), .GATE_OPEN_CYCLES(GOC)) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .count      (count),
        .free_slots (free_slots),
        .full       (full),
        .empty      (empty),
        .gate_open  (gate_open),
        .gate_dir   (gate_dir),
        .reject     (reject),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic ex, input logic [7:0] cnt,
                       input logic go, input logic dir, input logic rej);
        vec_t v;
        v.en = en; v.ex = ex; v.cnt = cnt; v.go = go; v.dir = dir; v.rej = rej;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic en, input logic ex, input logic [7:0] cnt,
                         input logic go, input logic dir, input logic rej);
        for (int k = 0; k < n; k++) add(en, ex, cnt, go, dir, rej);
    endtask

    // Drive inputs on the falling edge, check just after the next rising edge.
    task automatic step(input logic en, input logic ex);
        @(negedge clk);
        entry_req = en;
        exit_req  = ex;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic [7:0] cnt,
                                 input logic go, input logic dir, input logic rej);
        logic [1:0] exp_state;
        exp_state = !go ? 2'd0 : (dir ? 2'd1 : 2'd2);
        chk({tag, "_count"}, idx, 32'(count), 32'(cnt));
        chk({tag, "_free"},  idx, 32'(free_slots), 32'(CAP) - 32'(cnt));
        chk({tag, "_full"},  idx, 32'(full), 32'(cnt == 8'(CAP)));
        chk({tag, "_empty"}, idx, 32'(empty), 32'(cnt == 8'd0));
        chk({tag, "_gate"},  idx, 32'(gate_open), 32'(go));
        if (go) chk({tag, "_dir"}, idx, 32'(gate_dir), 32'(dir));
        chk({tag, "_reject"}, idx, 32'(reject), 32'(rej));
        chk({tag, "_state"}, idx, 32'(state_dbg), 32'(exp_state));
    endtask

    initial begin
        // en ex cnt go dir rej
        add(1, 0, 1, 1, 1, 0);          // 0: single entry
        add_n(3, 0, 0, 1, 1, 1, 0);     // 1-3: gate held 4 cycles
        add(0, 0, 1, 0, 1, 0);          // 4: gate closes
        add(1, 0, 2, 1, 1, 0);          // 5: second entry -> full
        add_n(3, 0, 0, 2, 1, 1, 0);
        add(0, 0, 2, 0, 1, 0);          // 9
        add(1, 0, 2, 0, 0, RJ);         // 10: third entry refused
        add(0, 0, 2, 0, 0, 0);          // 11: reject lasts one cycle
        add(0, 1, 1, 1, 0, 0);          // 12: exit
        add_n(3, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0);          // 16
        add(1, 1, 0, 1, 0, 0);          // 17: simultaneous, exit first
        add_n(3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);          // 21: single idle cycle
        add(0, 0, 1, 1, 1, 0);          // 22: held entry served
        add_n(3, 1, 0, 1, 1, 1, 0);     // 23-25: repeated entries coalesce
        add(0, 0, 1, 0, 1, 0);          // 26
        add(0, 0, 2, 1, 1, 0);          // 27: only one extra passage
        add(1, 0, 2, 1, 1, 0);          // 28: entry pending while going full
        add_n(2, 0, 0, 2, 1, 1, 0);
        add(0, 0, 2, 0, 1, 0);          // 31
        add(0, 0, 2, 0, 0, RJ);         // 32: pending entry discarded when full
        add(0, 0, 2, 0, 0, 0);          // 33
        add(0, 1, 1, 1, 0, 0);          // 34
        add_n(3, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0);          // 38
        add(0, 1, 0, 1, 0, 0);          // 39: last car leaves
        add_n(3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);          // 43
        add(0, 1, 0, 0, 0, 0);          // 44: exit while empty ignored
        add(0, 0, 0, 0, 0, 0);          // 45

        // Reset values while held in reset.
        #12;
        check_outputs("reset", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ex);
            check_outputs("vec", i, vecs[i].cnt, vecs[i].go, vecs[i].dir, vecs[i].rej);
        end

        // Reset mid-passage with an exit pending: outputs drop immediately, nothing follows.
        step(1, 0);
        check_outputs("midrst_open", 0, 8'd1, 1'b1, 1'b1, 1'b0);
        step(0, 1);
        check_outputs("midrst_pend", 1, 8'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        exit_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("midrst_async", 2, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("midrst_dir", 2, 32'(gate_dir), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            check_outputs("postrst", i, 8'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
